// File: rtl/input_conditioner_if.sv
// Signal bundle between the raw board pins and the conditioned input consumers.
// master drives the raw pins; slave is the conditioner itself.
interface input_conditioner_if #(
    parameter int NCH = 21
);
    logic [NCH-1:0] din;
    logic           tick;
    logic [NCH-1:0] dout;
    logic [NCH-1:0] rise;
    logic [NCH-1:0] fall;
    logic [NCH-1:0] long_press;
    logic           combo_res;

    modport master (
        output din,
        input  tick, dout, rise, fall, long_press, combo_res
    );

    modport slave (
        input  din,
        output tick, dout, rise, fall, long_press, combo_res
    );
endinterface

// File: rtl/input_conditioner.sv
// Button/switch conditioner: per-channel synchroniser, tick-driven debounce, edge and
// long-press pulses, plus a two-button hold sequencer that emits a stretched reset pulse.
//
// state    | meaning
// IDLE     | waiting for both combo buttons to be down
// ARM      | both down, counting ticks towards RES_HOLD
// FIRE     | combo_res high, counting RES_LEN cycles
// WAIT_REL | pulse done, waiting for release so one press gives one pulse
module input_conditioner #(
    parameter int NCH        = 21,
    parameter int PRESCALE   = 1000,
    parameter int DEBOUNCE_N = 8,
    parameter int LONG_TICKS = 1000,
    parameter int RES_A      = 0,
    parameter int RES_B      = 1,
    parameter int RES_HOLD   = 2000,
    parameter int RES_LEN    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input_conditioner_if.slave io
);
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DW = $clog2(DEBOUNCE_N + 1);
    localparam int HW = $clog2(LONG_TICKS + 1);
    localparam int CW = $clog2(RES_HOLD + 1);
    localparam int FW = $clog2(RES_LEN + 1);

    localparam logic [PW-1:0] P_LAST = PW'(PRESCALE - 1);
    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_N - 1);
    localparam logic [HW-1:0] H_MAX  = HW'(LONG_TICKS);
    localparam logic [HW-1:0] H_PRE  = HW'(LONG_TICKS - 1);
    localparam logic [CW-1:0] C_PRE  = CW'(RES_HOLD - 1);
    localparam logic [FW-1:0] F_PRE  = FW'(RES_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        FIRE,
        WAIT_REL
    } state_t;

    logic [NCH-1:0]         sync1;
    logic [NCH-1:0]         sync2;
    logic [PW-1:0]          pcnt;
    logic                   tick;
    logic [NCH-1:0][DW-1:0] dcnt;
    logic [NCH-1:0][HW-1:0] hcnt;
    logic [NCH-1:0]         dout_r;
    logic [NCH-1:0]         rise_r;
    logic [NCH-1:0]         fall_r;
    logic [NCH-1:0]         lp_r;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] ccnt;
    logic [CW-1:0] ccnt_nx;
    logic [FW-1:0] fcnt;
    logic [FW-1:0] fcnt_nx;
    logic          both;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= io.din;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + 1'b1;
        end
    end

    assign tick = (pcnt == P_LAST);

    // Edge pulses are set in the same clock that dout takes its new level.
    always_ff @(posedge clk) begin
        if (reset) begin
            dout_r <= '0;
            rise_r <= '0;
            fall_r <= '0;
            lp_r   <= '0;
            dcnt   <= '0;
            hcnt   <= '0;
        end else begin
            rise_r <= '0;
            fall_r <= '0;
            lp_r   <= '0;
            for (int i = 0; i < NCH; i++) begin
                if (tick) begin
                    if (sync2[i] == dout_r[i]) begin
                        dcnt[i] <= '0;
                    end else if (dcnt[i] == D_LAST) begin
                        dcnt[i]   <= '0;
                        dout_r[i] <= ~dout_r[i];
                        rise_r[i] <= ~dout_r[i];
                        fall_r[i] <= dout_r[i];
                    end else begin
                        dcnt[i] <= dcnt[i] + 1'b1;
                    end
                end

                if (!dout_r[i]) begin
                    hcnt[i] <= '0;
                end else if (tick && (hcnt[i] != H_MAX)) begin
                    hcnt[i] <= hcnt[i] + 1'b1;
                    if (hcnt[i] == H_PRE) begin
                        lp_r[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign both = dout_r[RES_A] & dout_r[RES_B];

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            ccnt  <= '0;
            fcnt  <= '0;
        end else begin
            state <= state_nx;
            ccnt  <= ccnt_nx;
            fcnt  <= fcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        ccnt_nx  = ccnt;
        fcnt_nx  = fcnt;
        case (state)
            IDLE: begin
                if (both) begin
                    state_nx = ARM;
                    ccnt_nx  = '0;
                end
            end
            ARM: begin
                if (!both) begin
                    state_nx = IDLE;
                end else if (tick) begin
                    ccnt_nx = ccnt + 1'b1;
                    if (ccnt == C_PRE) begin
                        state_nx = FIRE;
                        fcnt_nx  = '0;
                    end
                end
            end
            FIRE: begin
                // Pulse length is fixed once started; button state is ignored here.
                if (fcnt == F_PRE) begin
                    state_nx = WAIT_REL;
                end else begin
                    fcnt_nx = fcnt + 1'b1;
                end
            end
            WAIT_REL: begin
                if (!both) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign io.tick       = tick;
    assign io.dout       = dout_r;
    assign io.rise       = rise_r;
    assign io.fall       = fall_r;
    assign io.long_press = lp_r;
    assign io.combo_res  = (state == FIRE);
endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with a 4-channel, fast-tick configuration.
module tb_input_conditioner;
    localparam int NCH = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;
    int cr_cycles;
    int rise_sum;
    int fall_sum;
    int lp_sum;

    always #5 clk = ~clk;

    input_conditioner_if #(.NCH(NCH)) bus ();

    input_conditioner #(
        .NCH        (NCH),
        .PRESCALE   (4),
        .DEBOUNCE_N (3),
        .LONG_TICKS (5),
        .RES_A      (0),
        .RES_B      (1),
        .RES_HOLD   (2),
        .RES_LEN    (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .io    (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clr_acc();
        cr_cycles = 0;
        rise_sum  = 0;
        fall_sum  = 0;
        lp_sum    = 0;
    endtask

    // One clock out of reset; tick must be high exactly before every 4th edge.
    task automatic cyc1();
        check("tick", {31'b0, bus.tick}, (cyc % 4 == 3) ? 32'd1 : 32'd0);
        @(posedge clk);
        #1;
        cyc++;
        cr_cycles += int'(bus.combo_res);
        rise_sum  += $countones(bus.rise);
        fall_sum  += $countones(bus.fall);
        lp_sum    += $countones(bus.long_press);
    endtask

    // Advance to just after the n-th following tick edge.
    task automatic tk(input int n);
        for (int k = 0; k < n; k++) begin
            do cyc1(); while (cyc % 4 != 0);
        end
    endtask

    task automatic rst_cycle(input string tag);
        @(posedge clk);
        #1;
        check(tag, {14'b0, bus.tick, bus.dout, bus.rise, bus.fall, bus.long_press, bus.combo_res}, 32'd0);
    endtask

    initial begin
        clr_acc();
        bus.din = 4'hF;
        reset   = 1'b1;

        // 1: reset with inputs high, then debounce from zero
        for (int k = 0; k < 5; k++) rst_cycle("rst_outputs");
        reset = 1'b0;
        cyc   = 0;
        tk(2);
        check("t1_dout_early", bus.dout, 4'h0);
        clr_acc();
        tk(1);
        check("t1_dout", bus.dout, 4'hF);
        check("t1_rise", bus.rise, 4'hF);
        cyc1();
        check("t1_rise_off", bus.rise, 4'h0);
        check("t1_rise_count", rise_sum, 4);

        // all released; combo 0/1 were held long enough to fire once on the way
        bus.din = 4'h0;
        clr_acc();
        tk(3);
        check("t1_dout_fall", bus.dout, 4'h0);
        check("t1_fall", bus.fall, 4'hF);
        check("t1_combo_len", cr_cycles, 3);

        // 2: glitch on channel 2
        clr_acc();
        bus.din = 4'b0100;
        tk(2);
        bus.din = 4'b0000;
        tk(1);
        bus.din = 4'b0100;
        tk(2);
        check("t2_dout_pre", bus.dout, 4'h0);
        check("t2_no_pulse", rise_sum + fall_sum, 0);
        tk(1);
        check("t2_dout", bus.dout, 4'b0100);
        check("t2_rise", bus.rise, 4'b0100);
        bus.din = 4'b0000;
        tk(3);
        check("t2_fall", bus.fall, 4'b0100);

        // 3: long press on channel 3
        bus.din = 4'b1000;
        tk(3);
        check("t3_rise", bus.rise, 4'b1000);
        clr_acc();
        tk(4);
        check("t3_lp_early", lp_sum, 0);
        tk(1);
        check("t3_lp", bus.long_press, 4'b1000);
        tk(6);
        check("t3_lp_once", lp_sum, 1);
        bus.din = 4'b0000;
        clr_acc();
        tk(3);
        check("t3_fall", bus.fall, 4'b1000);
        cyc1();
        check("t3_fall_once", fall_sum, 1);
        check("t3_no_lp_release", lp_sum, 0);
        bus.din = 4'b1000;
        clr_acc();
        tk(8);
        check("t3_lp_again", bus.long_press, 4'b1000);
        check("t3_lp_again_count", lp_sum, 1);
        bus.din = 4'b0000;
        tk(3);

        // 4: combo hold, one pulse per press
        bus.din = 4'b0011;
        tk(3);
        check("t4_dout", bus.dout, 4'b0011);
        clr_acc();
        tk(1);
        check("t4_arm", bus.combo_res, 1'b0);
        tk(1);
        check("t4_fire", bus.combo_res, 1'b1);
        repeat (3) cyc1();
        check("t4_end", bus.combo_res, 1'b0);
        check("t4_len", cr_cycles, 3);
        tk(6);
        check("t4_no_refire", cr_cycles, 3);
        bus.din = 4'b0000;
        tk(3);
        check("t4_released", bus.dout, 4'h0);
        bus.din = 4'b0011;
        clr_acc();
        tk(5);
        check("t4_fire2", bus.combo_res, 1'b1);
        repeat (3) cyc1();
        check("t4_len2", cr_cycles, 3);
        bus.din = 4'b0000;
        tk(3);

        // 5: B dropped early, no pulse; a later full press still fires on time
        bus.din = 4'b0011;
        tk(1);
        bus.din = 4'b0001;
        clr_acc();
        tk(6);
        check("t5_dout", bus.dout, 4'b0001);
        check("t5_no_combo", cr_cycles, 0);
        bus.din = 4'b0011;
        tk(3);
        check("t5_both", bus.dout, 4'b0011);
        tk(1);
        check("t5_arm", bus.combo_res, 1'b0);
        tk(1);
        check("t5_fire", bus.combo_res, 1'b1);

        // 6: reset in FIRE, buttons still held
        reset = 1'b1;
        rst_cycle("t6_rst_clears");
        rst_cycle("t6_rst_hold");
        reset = 1'b0;
        cyc   = 0;
        clr_acc();
        tk(2);
        check("t6_dout_early", bus.dout, 4'h0);
        tk(1);
        check("t6_redebounce", bus.dout, 4'b0011);
        tk(1);
        check("t6_arm", bus.combo_res, 1'b0);
        tk(1);
        check("t6_refire", bus.combo_res, 1'b1);
        repeat (3) cyc1();
        check("t6_end", bus.combo_res, 1'b0);
        check("t6_len", cr_cycles, 3);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
